// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM encoding for the program loader, PC, boot ROM and imem.
package prog_loader_pkg;
  localparam int ADDR_W         = 26;
  localparam int DATA_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/prog_loader_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the last byte of a word.
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [DATA_W-1:0] o_word_nxt,
  output logic              o_word_full
);
  logic [DATA_W-BYTE_W-1:0] r_word;
  logic [BCNT_W-1:0]        r_cnt;

  // Word as it will look once the byte on i_byte is shifted in.
  assign o_word_nxt  = {r_word, i_byte};
  assign o_word_full = i_shift & (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // Shift register and byte counter; counter wraps to 0 on the last byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_nxt[DATA_W-BYTE_W-1:0];
      r_cnt  <= r_cnt + BCNT_W'(1);
    end else begin
      r_word <= r_word;
      r_cnt  <= r_cnt;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a program into imem: packs a valid/ready byte stream into words and writes them at consecutive addresses.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data,
  output logic              busy,
  output logic              done
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_num;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_data;
  logic              w_hs;
  logic              w_clear;
  logic              w_word_full;
  logic [DATA_W-1:0] w_word_nxt;

  // Handshake and strobes derive only from the registered state, with abort as a same-cycle veto.
  assign byte_ready = (r_state == ST_RECV) & ~abort;
  assign w_hs       = byte_valid & byte_ready;
  assign w_clear    = (r_state == ST_IDLE) | abort;
  assign imem_we    = (r_state == ST_WRITE) & ~abort;
  assign imem_addr  = r_imem_addr;
  assign imem_data  = r_imem_data;
  assign busy       = (r_state == ST_RECV) | (r_state == ST_WRITE);
  assign done       = (r_state == ST_DONE);

  prog_loader_word_packer u_word_packer (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_shift     (w_hs),
    .i_byte      (byte_data),
    .o_word_nxt  (w_word_nxt),
    .o_word_full (w_word_full)
  );

  // Load FSM with captured parameters, word index and the write address/data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_idx       <= '0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            r_base  <= base_addr;
            r_num   <= num_words;
            r_idx   <= '0;
            r_state <= (num_words == '0) ? ST_DONE : ST_RECV;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_word_full) begin
            // Address wraps modulo 2^ADDR_W by truncation.
            r_imem_addr <= r_base + r_idx;
            r_imem_data <= w_word_nxt;
            r_state     <= ST_WRITE;
          end else begin
            r_state <= ST_RECV;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_state <= (r_idx == r_num - ADDR_W'(1)) ? ST_DONE : ST_RECV;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized loads against a byte-stream model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  int                wr_cyc_q[$];
  int                hs_cyc_q[$];
  int                done_cyc_q[$];
  int                overlap_cnt = 0;
  int                rdy_bad = 0;

  prog_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Observer: records writes, done pulses and byte handshakes, sampled mid-cycle.
  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
      wr_cyc_q.push_back(cyc_cnt);
    end
    if (done) done_cyc_q.push_back(cyc_cnt);
    if (done && imem_we) overlap_cnt++;
    if (byte_valid && byte_ready) hs_cyc_q.push_back(cyc_cnt);
    if (byte_ready && !busy) rdy_bad++;
  end

  // Reference model: word i is bytes 4i..4i+3, first byte most significant.
  function automatic logic [31:0] model_word(input byte_q_t b, input int i);
    logic [31:0] w = 32'd0;
    for (int j = 0; j < 4; j++) w = w * 32'd256 + 32'(b[4*i+j]);
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base, input int i);
    longint a = (longint'(base) + longint'(i)) % (longint'(1) << ADDR_W);
    return a[ADDR_W-1:0];
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int j = 0; j < n; j++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    hs_cyc_q.delete(); done_cyc_q.delete();
    overlap_cnt = 0; rdy_bad = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    byte_data = 8'h00; base_addr = '0; num_words = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, output int s);
    s = cyc_cnt;
    start = 1'b1; base_addr = b; num_words = n;
    tick(1);
    start = 1'b0;
  endtask

  // Byte source: gap 0 = always valid, gap>0 = valid every gap-th cycle, gap<0 = random.
  task automatic feed(input byte_q_t bytes, input int gap, input int budget);
    int k = 0;
    int c = 0;
    while (k < bytes.size() && c < budget) begin
      if (gap == 0) byte_valid = 1'b1;
      else if (gap > 0) byte_valid = ((c % gap) == gap - 1);
      else byte_valid = 1'($urandom_range(0, 1));
      byte_data = bytes[k];
      @(negedge clock);
      if (byte_valid && byte_ready) k++;
      tick(1);
      c++;
    end
    byte_valid = 1'b0;
    byte_data = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cyc_q.size() == 0 && c < budget) begin tick(1); c++; end
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    byte_data = 8'h00; base_addr = '0; num_words = '0;
    tick(1);
    checks++;
    if ({byte_ready, imem_we, imem_addr, imem_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b required all 0",
               byte_ready, imem_we, imem_addr, imem_data, busy, done);
    end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_back_to_back();
    byte_q_t b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [DATA_W-1:0] exp_d[2] = '{32'h11223344, 32'h55667788};
    int s;
    clear_obs();
    start_load(26'h10, 26'd2, s);
    feed(b, 0, 40);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d writes required 2", wr_addr_q.size());
    end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== ADDR_W'(26'h10 + i) || wr_data_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_write%0d: got @%h=%h required @%h=%h", i, wr_addr_q[i], wr_data_q[i],
                 ADDR_W'(26'h10 + i), exp_d[i]);
      end
      checks++;
      if (hs_cyc_q.size() < 4*i+4 || wr_cyc_q[i] != hs_cyc_q[4*i+3] + 1) begin
        errors++; $display("FAIL b2b_latency%0d: write cycle %0d, 4th byte cycle not one before", i, wr_cyc_q[i]);
      end
    end
    checks++;
    if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
      errors++; $display("FAIL b2b_rate: writes %0d, spacing not 5 cycles", wr_cyc_q.size());
    end
    checks++;
    if (done_cyc_q.size() != 1 || wr_cyc_q.size() == 0 || done_cyc_q[0] != wr_cyc_q[$] + 1) begin
      errors++; $display("FAIL b2b_done: got %0d done pulses, required 1 the cycle after last write", done_cyc_q.size());
    end
    checks++;
    if (overlap_cnt != 0 || rdy_bad != 0) begin
      errors++; $display("FAIL b2b_exclusive: overlap=%0d ready_while_idle=%0d required 0/0", overlap_cnt, rdy_bad);
    end
  endtask

  task automatic test_zero_words();
    int s;
    clear_obs();
    start_load(ADDR_W'($urandom), 26'd0, s);
    byte_valid = 1'b1;
    tick(4);
    byte_valid = 1'b0;
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 1) begin
      errors++; $display("FAIL zero_done: got %0d pulses, required 1 at cycle %0d", done_cyc_q.size(), s + 1);
    end
    checks++;
    if (wr_addr_q.size() != 0 || hs_cyc_q.size() != 0) begin
      errors++; $display("FAIL zero_quiet: got %0d writes %0d handshakes required 0/0", wr_addr_q.size(), hs_cyc_q.size());
    end
  endtask

  task automatic test_gaps();
    byte_q_t b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [ADDR_W-1:0] base = ADDR_W'($urandom);
    int s;
    clear_obs();
    start_load(base, 26'd1, s);
    feed(b, 3, 60);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hDEADBEEF || wr_addr_q[0] !== base) begin
      errors++; $display("FAIL gaps_write: got %0d writes, required one @%h=deadbeef", wr_addr_q.size(), base);
    end
    checks++;
    if (hs_cyc_q.size() != 4 || wr_cyc_q.size() != 1 || wr_cyc_q[0] != hs_cyc_q[3] + 1) begin
      errors++; $display("FAIL gaps_timing: handshakes=%0d writes=%0d, write not right after 4th byte",
                         hs_cyc_q.size(), wr_cyc_q.size());
    end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++; $display("FAIL gaps_done: got %0d done pulses required 1", done_cyc_q.size());
    end
  endtask

  task automatic test_abort();
    byte_q_t b = rand_bytes(4);
    logic [ADDR_W-1:0] base = ADDR_W'($urandom);
    logic rdy;
    int s;
    clear_obs();
    start_load(base, 26'd3, s);
    feed(rand_bytes(2), 0, 20);
    abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
    @(negedge clock);
    rdy = byte_ready;
    tick(1);
    abort = 1'b0; byte_valid = 1'b0;
    tick(6);
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state: got ready=%b busy=%b required 0/0", rdy, busy);
    end
    checks++;
    if (wr_addr_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++; $display("FAIL abort_quiet: got %0d writes %0d done required 0/0", wr_addr_q.size(), done_cyc_q.size());
    end
    clear_obs();
    start_load(base, 26'd1, s);
    feed(b, 0, 20);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== model_word(b, 0) || wr_addr_q[0] !== base) begin
      errors++; $display("FAIL abort_restart: got %0d writes, required one @%h=%h", wr_addr_q.size(), base, model_word(b, 0));
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t b = rand_bytes(4);
    logic [ADDR_W-1:0] base = ADDR_W'($urandom);
    int s;
    clear_obs();
    start_load(base, 26'd2, s);
    feed(rand_bytes(2), 0, 20);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, imem_we, imem_addr, imem_data, busy, done} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b required all 0",
                         byte_ready, imem_we, imem_addr, imem_data, busy, done);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++; $display("FAIL midreset_nowrite: got %0d writes required 0", wr_addr_q.size());
    end
    clear_obs();
    start_load(base, 26'd1, s);
    feed(b, 0, 20);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== model_word(b, 0) || wr_addr_q[0] !== base) begin
      errors++; $display("FAIL midreset_restart: got %0d writes, required one @%h=%h", wr_addr_q.size(), base, model_word(b, 0));
    end
  endtask

  task automatic test_wrap();
    byte_q_t b = rand_bytes(8);
    int s;
    clear_obs();
    start_load(26'h3FFFFFF, 26'd2, s);
    start = 1'b1; base_addr = 26'h0000123; num_words = 26'd5;
    tick(1);
    start = 1'b0;
    feed(b, 0, 40);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 2 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL wrap_count: got %0d writes %0d done required 2/1", wr_addr_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== model_addr(26'h3FFFFFF, i) || wr_data_q[i] !== model_word(b, i)) begin
        errors++; $display("FAIL wrap_write%0d: got @%h=%h required @%h=%h", i, wr_addr_q[i], wr_data_q[i],
                           model_addr(26'h3FFFFFF, i), model_word(b, i));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 4);
      logic [ADDR_W-1:0] base = ADDR_W'($urandom);
      byte_q_t b = rand_bytes(4 * n);
      int s;
      clear_obs();
      start_load(base, ADDR_W'(n), s);
      feed(b, -1, 400);
      wait_done(40);
      checks++;
      if (wr_addr_q.size() != n || done_cyc_q.size() != 1) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes %0d done required %0d/1", t, wr_addr_q.size(), done_cyc_q.size(), n);
      end
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== model_addr(base, i) || wr_data_q[i] !== model_word(b, i)) begin
          errors++; $display("FAIL rand%0d_write%0d: got @%h=%h required @%h=%h", t, i, wr_addr_q[i], wr_data_q[i],
                             model_addr(base, i), model_word(b, i));
        end
      end
      checks++;
      if (overlap_cnt != 0 || rdy_bad != 0 || wr_cyc_q.size() == 0 || done_cyc_q.size() == 0 ||
          done_cyc_q[0] != wr_cyc_q[$] + 1) begin
        errors++; $display("FAIL rand%0d_done_timing: overlap=%0d ready_while_idle=%0d, done not right after last write",
                           t, overlap_cnt, rdy_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_back_to_back();
    test_zero_words();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
